// File: rtl/vga_line_fetch_if.sv
// vga_line_fetch_if: pixel memory read bus, request held with address until ack
interface vga_line_fetch_if #(parameter int ADDR_W = 21);
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic [29:0]       mem_rdata;
   modport master(output mem_req, mem_addr, input mem_ack, mem_rdata);
   modport slave(input mem_req, mem_addr, output mem_ack, mem_rdata);
endinterface

// File: rtl/vga_line_fetch.sv
// vga_line_fetch: prefetches the next active line into a ping-pong buffer and
// serves packed RGB to the timing driver from the other bank.
module vga_line_fetch #(
   parameter int H_ACT   = 1280,
   parameter int V_ACT   = 1024,
   parameter int ADDR_W  = 21,
   parameter int FB_BASE = 0
) (
   input  logic                    clk27,
   input  logic                    rst27,
   input  logic [10:0]             current_x,
   input  logic [9:0]              current_y,
   input  logic                    request,
   output logic [9:0]              r,
   output logic [9:0]              g,
   output logic [9:0]              b,
   output logic                    underrun,
   vga_line_fetch_if.master        mem
);
   localparam int BW = $clog2(2*H_ACT);
   localparam int CW = $clog2(H_ACT);
   localparam logic [CW-1:0]     C_LAST = CW'(H_ACT-1);
   localparam logic [9:0]        Y_LAST = 10'(V_ACT-1);
   localparam logic [ADDR_W-1:0] A_BASE = ADDR_W'(FB_BASE);
   localparam logic [ADDR_W-1:0] A_LINE = ADDR_W'(H_ACT);

   typedef enum logic {IDLE, FETCH} state_t;
   state_t state, state_n;

   logic [29:0]       line_buf [2*H_ACT];
   logic [29:0]       pix;
   logic              req_d, eol, acc, we, wbank, wbank_n, underrun_n;
   logic [CW-1:0]     cnt, cnt_n;
   logic [ADDR_W-1:0] addr_n;
   logic [9:0]        tgt, tgt_n, next_y;
   logic [1:0]        valid, valid_n;
   logic [1:0][9:0]   tag, tag_n;
   logic [BW-1:0]     rd_idx, wr_idx;

   assign eol    = req_d & ~request;
   assign next_y = (current_y == Y_LAST) ? '0 : current_y + 10'd1;
   assign acc    = mem.mem_req & mem.mem_ack;
   assign rd_idx = current_y[0] ? BW'(H_ACT) + BW'(current_x) : BW'(current_x);
   assign wr_idx = wbank ? BW'(H_ACT) + BW'(cnt) : BW'(cnt);
   assign {r, g, b} = req_d ? pix : '0;

   // Buffer has no reset so it maps onto block RAM; blanking comes from req_d.
   always_ff @(posedge clk27) begin
      if (we) line_buf[wr_idx] <= mem.mem_rdata;
      pix <= line_buf[rd_idx];
   end

   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      addr_n     = mem.mem_addr;
      wbank_n    = wbank;
      tgt_n      = tgt;
      valid_n    = valid;
      tag_n      = tag;
      we         = 1'b0;
      underrun_n = underrun | (request & ~req_d &
                   (~valid[current_y[0]] | (tag[current_y[0]] != current_y)));
      if (eol) begin
         // A fetch still running here is aborted; its ack this clock is dropped.
         state_n          = FETCH;
         cnt_n            = '0;
         addr_n           = A_BASE + ADDR_W'(next_y) * A_LINE;
         wbank_n          = next_y[0];
         tgt_n            = next_y;
         valid_n[next_y[0]] = 1'b0;
         underrun_n       = underrun_n | (state == FETCH);
      end else if (state == FETCH && acc) begin
         we     = 1'b1;
         cnt_n  = cnt + CW'(1);
         addr_n = mem.mem_addr + ADDR_W'(1);
         if (cnt == C_LAST) begin
            state_n        = IDLE;
            valid_n[wbank] = 1'b1;
            tag_n[wbank]   = tgt;
         end
      end
   end

   always_ff @(posedge clk27 or posedge rst27) begin
      if (rst27) begin
         state        <= FETCH;
         cnt          <= '0;
         mem.mem_addr <= A_BASE;
         mem.mem_req  <= 1'b0;
         wbank        <= 1'b0;
         tgt          <= '0;
         valid        <= '0;
         tag          <= '0;
         underrun     <= 1'b0;
         req_d        <= 1'b0;
      end else begin
         state        <= state_n;
         cnt          <= cnt_n;
         mem.mem_addr <= addr_n;
         mem.mem_req  <= (state_n == FETCH);
         wbank        <= wbank_n;
         tgt          <= tgt_n;
         valid        <= valid_n;
         tag          <= tag_n;
         underrun     <= underrun_n;
         req_d        <= request;
      end
   end
endmodule

// File: tb/tb_vga_line_fetch.sv
// tb_vga_line_fetch: directed bench; memory returns its own word address as pixel data.
module tb_vga_line_fetch;
   localparam int H = 1280;
   localparam int V = 8;

   logic        clk27 = 1'b0;
   logic        rst27 = 1'b1;
   logic [10:0] current_x = '0;
   logic [9:0]  current_y = '0;
   logic        request = 1'b0;
   logic [9:0]  r, g, b;
   logic        underrun;
   int          tests = 0;
   int          fails = 0;
   int          ack_per = 1;
   int          cyc;
   int          acks;
   logic [20:0] last_addr;

   vga_line_fetch_if #(.ADDR_W(21)) m();

   vga_line_fetch #(.H_ACT(H), .V_ACT(V), .ADDR_W(21), .FB_BASE(0)) dut (
      .clk27(clk27), .rst27(rst27), .current_x(current_x), .current_y(current_y),
      .request(request), .r(r), .g(g), .b(b), .underrun(underrun), .mem(m)
   );

   always #5 clk27 = ~clk27;

   assign m.mem_ack   = (cyc % ack_per) == 0;
   assign m.mem_rdata = 30'(m.mem_addr);

   always_ff @(posedge clk27) begin
      cyc <= cyc + 1;
      if (m.mem_req && m.mem_ack) begin
         acks      <= acks + 1;
         last_addr <= m.mem_addr;
      end
   end

   task tick;
      @(posedge clk27);
      #1;
   endtask

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_done(string tag);
      int n = 0;
      while (m.mem_req && n < 6000) begin
         tick;
         n++;
      end
      check(tag, 32'(m.mem_req), 32'd0);
   endtask

   task automatic show_line(int y, bit chk);
      int nxt = (y == V-1) ? 0 : y + 1;
      current_y = 10'(y);
      for (int x = 0; x < H; x++) begin
         request   = 1'b1;
         current_x = 11'(x);
         tick;
         if (chk) check($sformatf("pix_y%0d_x%0d", y, x), 32'({r, g, b}), 32'(y*H + x));
      end
      request = 1'b0;
      tick;
      check($sformatf("blank_y%0d", y), 32'({r, g, b}), 32'd0);
      check($sformatf("fetch_addr_y%0d", y), 32'(m.mem_addr), 32'(nxt*H));
      check($sformatf("fetch_req_y%0d", y), 32'(m.mem_req), 32'd1);
   endtask

   initial begin
      int a0;
      int n;
      repeat (3) tick;
      check("rst_rgb", 32'({r, g, b}), 32'd0);
      check("rst_req", 32'(m.mem_req), 32'd0);
      check("rst_addr", 32'(m.mem_addr), 32'd0);
      check("rst_underrun", 32'(underrun), 32'd0);

      a0 = acks;
      rst27 = 1'b0;
      tick;
      check("start_req", 32'(m.mem_req), 32'd1);
      check("start_addr", 32'(m.mem_addr), 32'd0);
      wait_done("t1_done");
      check("t1_acks", 32'(acks - a0), 32'(H));
      check("t1_last_addr", 32'(last_addr), 32'(H-1));
      repeat (4) tick;

      // One full frame (wraps at the last line), then line 0 of the next frame
      for (int y = 0; y < V; y++) begin
         show_line(y, y == 0 || y == 6 || y == V-1);
         wait_done($sformatf("line_done_y%0d", y));
         check($sformatf("underrun_y%0d", y), 32'(underrun), 32'd0);
         repeat (4) tick;
      end
      show_line(0, 1'b1);
      wait_done("frame2_done");
      check("frame2_underrun", 32'(underrun), 32'd0);
      repeat (4) tick;

      // Slow memory: fetch of line 2 cannot finish before line 2 ends
      ack_per = 4;
      a0 = acks;
      show_line(1, 1'b0);
      repeat (40) tick;
      check("t5_addr_tracks_acks", 32'(m.mem_addr), 32'(2*H + (acks - a0)));
      check("t5_no_underrun_yet", 32'(underrun), 32'd0);
      show_line(2, 1'b0);
      check("t5_underrun", 32'(underrun), 32'd1);
      repeat (20) tick;
      check("t5_underrun_sticky", 32'(underrun), 32'd1);

      // Async reset in the middle of the restarted fetch of line 3
      a0 = acks;
      n = 0;
      while (acks - a0 < 600 && n < 10000) begin
         tick;
         n++;
      end
      check("t6_reached_600", 32'(acks - a0 >= 600), 32'd1);
      current_y = 10'd1;
      current_x = 11'd1000;
      request   = 1'b1;
      tick;
      check("t6_pre_rgb", 32'({r, g, b}), 32'(H + 1000));
      #2;
      rst27 = 1'b1;
      #1;
      check("t6_rgb", 32'({r, g, b}), 32'd0);
      check("t6_req", 32'(m.mem_req), 32'd0);
      check("t6_addr", 32'(m.mem_addr), 32'd0);
      check("t6_underrun", 32'(underrun), 32'd0);
      request = 1'b0;
      ack_per = 1;
      repeat (2) tick;
      rst27 = 1'b0;
      tick;
      check("t6_restart_req", 32'(m.mem_req), 32'd1);
      check("t6_restart_addr", 32'(m.mem_addr), 32'd0);
      wait_done("t6_done");
      repeat (4) tick;
      show_line(0, 1'b1);
      check("t6_line0_underrun", 32'(underrun), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
